// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - PC-control bundle between fetch_redirect_ctrl and its pipeline neighbours
//
// Groups the redirect/hazard inputs and the PC-control / flush / counter outputs.
//   slave  : the controller (consumes redirects and hazards, drives PC controls)
//   master : the surrounding pipeline (drives redirects and hazards, consumes PC controls)
interface fetch_redirect_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      pc_curr;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             jump_req;
    logic [31:0]      jump_target;
    logic             load_use_hazard;
    logic             imem_wait;
    logic             stall;
    logic             jump_cs;
    logic [31:0]      Next_pc;
    logic             flush_ifid;
    logic             flush_idex;
    logic [CNT_W-1:0] redirect_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  pc_curr, branch_taken, branch_target, jump_req, jump_target,
               load_use_hazard, imem_wait,
        output stall, jump_cs, Next_pc, flush_ifid, flush_idex,
               redirect_cnt, stall_cnt
    );

    modport master (
        output pc_curr, branch_taken, branch_target, jump_req, jump_target,
               load_use_hazard, imem_wait,
        input  stall, jump_cs, Next_pc, flush_ifid, flush_idex,
               redirect_cnt, stall_cnt
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - PC redirect/stall arbitration with pending-redirect hold and perf counters
//
// Ports:
//   clk    : clock, all state updates on posedge
//   rst_n  : synchronous active-low reset
//   bus    : fetch_redirect_ctrl_if.slave
//            in : pc_curr, branch_taken/branch_target, jump_req/jump_target,
//                 load_use_hazard, imem_wait
//            out: stall, jump_cs, Next_pc, flush_ifid, flush_idex,
//                 redirect_cnt, stall_cnt
// All PC controls are combinational so the PC register acts on them in the same cycle.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'd0,
    parameter int          CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_redirect_ctrl_if.slave  bus
);
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PENDING = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]  state, state_d;
    logic [31:0] pend_target, pend_target_d;
    logic        pend_ex, pend_ex_d;

    logic [CNT_W-1:0] redirect_cnt_q, stall_cnt_q;

    logic        stall_src;
    logic        live_valid;
    logic [31:0] live_target;
    logic        issue_ex;
    logic        stall_c, jump_cs_c;
    logic [31:0] next_pc_c;
    logic        redirect_fire;

    // A taken EX branch squashes the instruction that would have caused the
    // load-use stall, so it cancels that stall source.
    assign stall_src   = bus.imem_wait | (bus.load_use_hazard & ~bus.branch_taken);

    // Older (EX) instruction wins over the younger (ID) one.
    assign live_valid  = bus.branch_taken | bus.jump_req;
    assign live_target = bus.branch_taken ? bus.branch_target : bus.jump_target;

    always_comb begin
        state_d       = state;
        pend_target_d = pend_target;
        pend_ex_d     = pend_ex;
        stall_c       = stall_src;
        jump_cs_c     = 1'b0;
        next_pc_c     = bus.pc_curr + 32'd1;
        issue_ex      = 1'b0;

        case (state)
            S_IDLE: begin
                if (live_valid) begin
                    if (!stall_src) begin
                        jump_cs_c = 1'b1;
                        next_pc_c = live_target;
                        issue_ex  = bus.branch_taken;
                    end else begin
                        pend_target_d = live_target;
                        pend_ex_d     = bus.branch_taken;
                        state_d       = S_PENDING;
                    end
                end
            end
            default: begin
                if (stall_src) begin
                    // Only an older EX branch may displace a held ID jump.
                    if (!pend_ex && bus.branch_taken) begin
                        pend_target_d = bus.branch_target;
                        pend_ex_d     = 1'b1;
                    end
                end else begin
                    jump_cs_c = 1'b1;
                    state_d   = S_IDLE;
                    if (!pend_ex && bus.branch_taken) begin
                        next_pc_c = bus.branch_target;
                        issue_ex  = 1'b1;
                    end else begin
                        next_pc_c = pend_target;
                        issue_ex  = pend_ex;
                    end
                end
            end
        endcase
    end

    assign redirect_fire = jump_cs_c & ~stall_c;

    // During reset the PC is loaded with the reset vector and both pipeline
    // registers are squashed.
    always_comb begin
        if (!rst_n) begin
            bus.stall      = 1'b0;
            bus.jump_cs    = 1'b1;
            bus.Next_pc    = RESET_VECTOR;
            bus.flush_ifid = 1'b1;
            bus.flush_idex = 1'b1;
        end else begin
            bus.stall      = stall_c;
            bus.jump_cs    = jump_cs_c;
            bus.Next_pc    = next_pc_c;
            bus.flush_ifid = redirect_fire;
            bus.flush_idex = redirect_fire & issue_ex;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            pend_target    <= 32'd0;
            pend_ex        <= 1'b0;
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            state       <= state_d;
            pend_target <= pend_target_d;
            pend_ex     <= pend_ex_d;
            if (redirect_fire && redirect_cnt_q != CNT_MAX)
                redirect_cnt_q <= redirect_cnt_q + 1'b1;
            if (stall_c && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign bus.redirect_cnt = redirect_cnt_q;
    assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.CNT_W(CNT_W)) bus ();

    fetch_redirect_ctrl #(
        .RESET_VECTOR(32'h40),
        .CNT_W       (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Commit one clock edge, then leave inputs changeable 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic bt, input logic [31:0] btgt, input logic jr,
                         input logic [31:0] jtgt, input logic lu, input logic iw,
                         input logic [31:0] pc);
        bus.branch_taken    = bt;
        bus.branch_target   = btgt;
        bus.jump_req        = jr;
        bus.jump_target     = jtgt;
        bus.load_use_hazard = lu;
        bus.imem_wait       = iw;
        bus.pc_curr         = pc;
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic st, input logic jc,
                           input logic [31:0] npc, input logic fi, input logic fe);
        chk({tag, ".stall"},   {31'd0, bus.stall},      {31'd0, st});
        chk({tag, ".jump_cs"}, {31'd0, bus.jump_cs},    {31'd0, jc});
        chk({tag, ".next_pc"}, bus.Next_pc,             npc);
        chk({tag, ".f_ifid"},  {31'd0, bus.flush_ifid}, {31'd0, fi});
        chk({tag, ".f_idex"},  {31'd0, bus.flush_idex}, {31'd0, fe});
    endtask

    task automatic chk_cnt(input string tag, input int rc, input int sc);
        chk({tag, ".redirect_cnt"}, {16'd0, bus.redirect_cnt}, rc);
        chk({tag, ".stall_cnt"},    {16'd0, bus.stall_cnt},    sc);
    endtask

    initial begin
        // Reset: forced outputs, stall suppressed even with imem_wait high.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'h1234);
        chk_ctl("rst0", 0, 1, 32'h40, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h1234);
        chk_ctl("rst1", 0, 1, 32'h40, 1, 1);
        tick();
        chk_cnt("rst", 0, 0);

        // Sequential fetch from the reset vector.
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h40);
        chk_ctl("seq40", 0, 0, 32'h41, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h41);
        chk_ctl("seq41", 0, 0, 32'h42, 0, 0);
        tick();
        chk_cnt("seq", 0, 0);

        // Unstalled ID jump.
        drive(0, 0, 1, 32'h100, 0, 0, 32'h42);
        chk_ctl("jmp", 0, 1, 32'h100, 1, 0);
        tick();
        chk_cnt("jmp", 1, 0);

        // Wrap of sequential next PC.
        drive(0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF);
        chk_ctl("wrap", 0, 0, 32'h0, 0, 0);

        // EX branch beats ID jump.
        drive(1, 32'h200, 1, 32'h300, 0, 0, 32'h100);
        chk_ctl("arb", 0, 1, 32'h200, 1, 1);
        tick();
        chk_cnt("arb", 2, 0);

        // ID jump held through a 3-cycle imem stall.
        drive(0, 0, 1, 32'h80, 0, 1, 32'h200);
        chk_ctl("pend0", 1, 0, 32'h201, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h200);
        chk_ctl("pend1", 1, 0, 32'h201, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'h200);
        chk_ctl("pend2", 1, 0, 32'h201, 0, 0);
        tick();
        chk_cnt("pend", 2, 3);
        drive(0, 0, 0, 0, 0, 0, 32'h200);
        chk_ctl("pend_rel", 0, 1, 32'h80, 1, 0);
        tick();
        chk_cnt("pend_rel", 3, 3);

        // Held ID jump displaced by an EX branch during the stall.
        drive(0, 0, 1, 32'h80, 0, 1, 32'h300);
        tick();
        drive(1, 32'h90, 0, 0, 0, 1, 32'h300);
        chk_ctl("ovr_hold", 1, 0, 32'h301, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h300);
        chk_ctl("ovr_rel", 0, 1, 32'h90, 1, 1);
        tick();
        chk_cnt("ovr", 4, 5);

        // EX branch arriving in the same cycle the stall clears.
        drive(0, 0, 1, 32'h80, 0, 1, 32'h400);
        tick();
        drive(1, 32'hA0, 0, 0, 0, 0, 32'h400);
        chk_ctl("same_rel", 0, 1, 32'hA0, 1, 1);
        tick();
        chk_cnt("same", 5, 6);

        // Held EX branch ignores a later EX branch.
        drive(1, 32'hB0, 0, 0, 0, 1, 32'h500);
        tick();
        drive(1, 32'hC0, 0, 0, 0, 1, 32'h500);
        chk_ctl("ex_hold", 1, 0, 32'h501, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h500);
        chk_ctl("ex_rel", 0, 1, 32'hB0, 1, 1);
        tick();
        chk_cnt("ex", 6, 8);

        // Reset while pending discards the held redirect.
        drive(0, 0, 1, 32'h80, 0, 1, 32'h600);
        tick();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 32'h600);
        chk_ctl("rst_pend", 0, 1, 32'h40, 1, 1);
        tick();
        chk_cnt("rst_pend", 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h40);
        chk_ctl("after_rst", 0, 0, 32'h41, 0, 0);
        tick();

        // Taken branch cancels the load-use stall.
        drive(1, 32'h10, 0, 0, 1, 0, 32'h41);
        chk_ctl("lu_br", 0, 1, 32'h10, 1, 1);
        tick();
        chk_cnt("lu_br", 1, 0);

        // Load-use alone: stall counter saturation.
        drive(0, 0, 0, 0, 1, 0, 32'h10);
        chk_ctl("lu", 1, 0, 32'h11, 0, 0);
        for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
            @(posedge clk);
        end
        #1;
        chk_cnt("sat", 1, 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Drives the program counter's control inputs (`stall`, `jump_cs`, `Next_pc`) from pipeline redirect and hazard sources.
- Arbitrates between an EX-stage taken branch and an ID-stage jump, and holds a redirect that arrives while the PC is stalled until the stall clears.
- Issues IF/ID and ID/EX flushes.
- Forces the PC to a reset vector during reset and keeps stall/redirect performance counters.
- Sits in IF, beside the PC register.

Parameters:
- RESET_VECTOR, 32'd0, word address loaded into the PC while reset is asserted.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- pc_curr  in  32  current PC from the program counter (word address).
- branch_taken  in  1  EX-stage branch resolved taken, valid this cycle.
- branch_target  in  32  EX branch target (word address).
- jump_req  in  1  ID-stage jump decoded, valid this cycle.
- jump_target  in  32  ID jump target (word address).
- load_use_hazard  in  1  load-use hazard detected in ID.
- imem_wait  in  1  instruction memory not ready.
- stall  out  1  to PC; PC holds when 1.
- jump_cs  out  1  to PC; PC loads `Next_pc` when 1 and `stall`=0.
- Next_pc  out  32  redirect target to PC.
- flush_ifid  out  1  squash IF/ID register.
- flush_idex  out  1  squash ID/EX register.
- redirect_cnt  out  CNT_W  cycles with `jump_cs`=1 (excluding reset).
- stall_cnt  out  CNT_W  cycles with `stall`=1.

Behaviour:
- Control outputs (`stall`, `jump_cs`, `Next_pc`, flushes) are combinational from inputs and state, so the PC sees them in the same cycle. State, pending register and counters are registered.
- PC is word-addressed; sequential next = `pc_curr` + 1, mod 2^32.
- `stall_src` = `imem_wait` | (`load_use_hazard` & ~`branch_taken`). A taken EX branch cancels the load-use stall because the stalling instruction is squashed.
- Live redirect: `branch_taken` beats `jump_req` (older instruction wins).
  - `branch_taken` gives kind EX, target `branch_target`.
  - Otherwise `jump_req` gives kind ID, target `jump_target`.
- State IDLE:
  - Live redirect & ~`stall_src`: `jump_cs`=1, `Next_pc`=target, `stall`=0. Stay IDLE.
  - Live redirect & `stall_src`: `jump_cs`=0, `stall`=1. Latch target and kind into `pend_target` / `pend_ex`; go PENDING.
  - No redirect: `jump_cs`=0, `Next_pc`=`pc_curr`+1, `stall`=`stall_src`.
- State PENDING:
  - `stall`=`stall_src`.
  - While `stall_src`=1: `jump_cs`=0. If `pend_ex`=0 and `branch_taken`=1, overwrite pending with the EX branch (`pend_ex`=1). Otherwise ignore new redirects.
  - When `stall_src`=0: `jump_cs`=1 and go IDLE.
    - `Next_pc`=`pend_target`, unless `pend_ex`=0 and `branch_taken`=1 in the same cycle; then `branch_target` is used and the kind is EX.
- Flushes:
  - `flush_ifid`=1 exactly in cycles where `jump_cs`=1 and `stall`=0.
  - `flush_idex`=1 in those cycles only if the issued redirect kind is EX.
- Reset (`rst_n`=0, sampled at posedge):
  - State → IDLE, `pend_target`→0, `pend_ex`→0, both counters→0.
  - While `rst_n`=0 the combinational outputs are forced: `jump_cs`=1, `Next_pc`=RESET_VECTOR, `stall`=0, `flush_ifid`=1, `flush_idex`=1. This gives the PC its reset value.
  - Reset mid-PENDING discards the pending redirect.
- Counters:
  - Increment at posedge when their condition holds and `rst_n`=1.
  - Saturate at all-ones, no wrap.
  - The `redirect_cnt` condition is `jump_cs`=1 & `stall`=0.

Test Plan:
- Hold `rst_n`=0 for 2 cycles with RESET_VECTOR=0x40 → `jump_cs`=1, `Next_pc`=0x40, both flushes=1. Release → PC=0x40 and increments 0x41, 0x42; counters=0.
- `jump_req`=1, `jump_target`=0x100, no stall → same cycle `jump_cs`=1, `Next_pc`=0x100, `flush_ifid`=1, `flush_idex`=0. Next PC=0x100, `redirect_cnt`=1.
- `branch_taken`=1 (target 0x200) and `jump_req`=1 (target 0x300) together → `Next_pc`=0x200, both flushes=1.
- `imem_wait`=1 for 3 cycles while `jump_req`=1 (target 0x80) in the first cycle:
  - `stall`=1 for 3 cycles, `jump_cs`=0, `stall_cnt`=3.
  - In the cycle `imem_wait` drops, `jump_cs`=1 with `Next_pc`=0x80.
- PENDING with ID jump 0x80, then `branch_taken` (target 0x90) during the stall → on release `Next_pc`=0x90, `flush_idex`=1.
- `load_use_hazard`=1 with `branch_taken`=1 (target 0x10) → `stall`=0, `jump_cs`=1. Separately, assert `load_use_hazard` alone for 2^CNT_W+5 cycles → `stall_cnt` saturates at 0xFFFF.
